// File: rtl/coastal_pkg.sv
// Shared types and default sizing for the coastal alert broadcast arbiter.
package coastal_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BCAST = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int DEF_N_ZONES      = 4;
   localparam int DEF_BCAST_CYCLES = 8;
   localparam int DEF_GAP_CYCLES   = 2;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/coastal_alert_arbiter_rr_picker.sv
// Round-robin winner select: searches upward from the zone after ptr, wrapping once.
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic [IW-1:0] idx,
   output logic          valid
);

   int cand;

   always_comb begin
      win   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = 0;
      for (int i = 1; i <= N; i++) begin
         cand = (int'(ptr) + i) % N;
         if (!valid && req[cand[IW-1:0]]) begin
            valid               = 1'b1;
            win[cand[IW-1:0]]   = 1'b1;
            idx                 = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/coastal_alert_arbiter.sv
// Shares one siren/radio channel between coastal zones: crisis requests beat
// investigation requests, round-robin within each class, fixed slot plus guard gap.
//
//   state | meaning
//   IDLE  | channel free, arbitrating every clock
//   BCAST | slot running, grant held; investigation slots abort on any crisis request
//   GAP   | guard time, grant zero; arbitration happens on its last clock
module coastal_alert_arbiter
   import coastal_pkg::*;
#(
   parameter int N_ZONES      = DEF_N_ZONES,
   parameter int BCAST_CYCLES = DEF_BCAST_CYCLES,
   parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_ZONES-1:0]         kritis_req,
   input  logic [N_ZONES-1:0]         invest_req,
   output logic [N_ZONES-1:0]         gnt,
   output logic                       gnt_kritis,
   output logic [$clog2(N_ZONES)-1:0] bcast_zone,
   output logic                       bcast_done,
   output logic                       preempted
);

   localparam int IW = $clog2(N_ZONES);
   localparam int CW = $clog2(max2(BCAST_CYCLES, GAP_CYCLES) + 1);
   localparam logic [CW-1:0] BCAST_LOAD = CW'(BCAST_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [IW-1:0]       kptr, iptr;
   logic [N_ZONES-1:0]  k_win, i_win, invest_only;
   logic [IW-1:0]       k_idx, i_idx;
   logic                k_valid, i_valid;
   logic                arb_now;

   // a zone raising both classes competes only as crisis
   assign invest_only = invest_req & ~kritis_req;

   rr_picker #(.N(N_ZONES), .IW(IW)) u_pick_kritis (
      .req   (kritis_req),
      .ptr   (kptr),
      .win   (k_win),
      .idx   (k_idx),
      .valid (k_valid)
   );

   rr_picker #(.N(N_ZONES), .IW(IW)) u_pick_invest (
      .req   (invest_only),
      .ptr   (iptr),
      .win   (i_win),
      .idx   (i_idx),
      .valid (i_valid)
   );

   // the last gap clock doubles as an arbitration clock so gaps stay exactly GAP_CYCLES
   assign arb_now = (state == IDLE) || ((state == GAP) && (cnt == '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         kptr       <= IW'(N_ZONES - 1);
         iptr       <= IW'(N_ZONES - 1);
         gnt        <= '0;
         gnt_kritis <= 1'b0;
         bcast_zone <= '0;
         bcast_done <= 1'b0;
         preempted  <= 1'b0;
      end else begin
         bcast_done <= 1'b0;
         preempted  <= 1'b0;
         if (arb_now) begin
            if (k_valid) begin
               state      <= BCAST;
               cnt        <= BCAST_LOAD;
               gnt        <= k_win;
               gnt_kritis <= 1'b1;
               bcast_zone <= k_idx;
               kptr       <= k_idx;
               bcast_done <= (BCAST_CYCLES == 1);
            end else if (i_valid) begin
               state      <= BCAST;
               cnt        <= BCAST_LOAD;
               gnt        <= i_win;
               gnt_kritis <= 1'b0;
               bcast_zone <= i_idx;
               iptr       <= i_idx;
               bcast_done <= (BCAST_CYCLES == 1);
            end else begin
               state <= IDLE;
               cnt   <= '0;
            end
         end else if (state == BCAST) begin
            if ((cnt == '0) || (!gnt_kritis && k_valid)) begin
               state      <= GAP;
               cnt        <= GAP_LOAD;
               gnt        <= '0;
               gnt_kritis <= 1'b0;
               bcast_zone <= '0;
               preempted  <= (cnt != '0);
            end else begin
               cnt        <= cnt - CW'(1);
               bcast_done <= (cnt == CW'(1));
            end
         end else begin
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_coastal_alert_arbiter.sv
// Vector table plus hand sequences; expected per-cycle outputs queued and compared each cycle.
module tb_coastal_alert_arbiter;

   localparam int NZ = 4;
   localparam int BC = 8;
   localparam int GC = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [NZ-1:0] kritis_req, invest_req, gnt;
   logic          gnt_kritis;
   logic [1:0]    bcast_zone;
   logic          bcast_done, preempted;

   always #5 clk = ~clk;

   coastal_alert_arbiter #(
      .N_ZONES(NZ), .BCAST_CYCLES(BC), .GAP_CYCLES(GC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .kritis_req (kritis_req),
      .invest_req (invest_req),
      .gnt        (gnt),
      .gnt_kritis (gnt_kritis),
      .bcast_zone (bcast_zone),
      .bcast_done (bcast_done),
      .preempted  (preempted)
   );

   typedef struct packed {
      logic [3:0] g;
      logic       k;
      logic [1:0] zone;
      logic       done;
      logic       pre;
   } out_t;

   typedef struct {
      logic [3:0] k_in;
      logic [3:0] i_in;
      logic [3:0] g;
      logic       gk;
   } vec_t;

   out_t  sb[$];
   vec_t  vt[9];
   int    checks = 0;
   int    failures = 0;
   string phase = "init";

   function automatic logic [1:0] oh2i(input logic [3:0] g);
      logic [1:0] r;
      r = 2'd0;
      for (int b = 0; b < 4; b++) if (g[b]) r = 2'(b);
      return r;
   endfunction

   task automatic push_out(input logic [3:0] g, input logic k, input logic done, input logic pre);
      out_t e;
      e.g = g; e.k = k; e.zone = oh2i(g); e.done = done; e.pre = pre;
      sb.push_back(e);
   endtask

   // len granted clocks (done on last if full), then the guard gap
   task automatic push_slot(input logic [3:0] g, input logic k, input int len, input logic full);
      for (int c = 0; c < len; c++) push_out(g, k, full && (c == len - 1), 1'b0);
      for (int c = 0; c < GC; c++) push_out(4'b0, 1'b0, 1'b0, !full && (c == 0));
   endtask

   task automatic push_idle(input int n);
      for (int c = 0; c < n; c++) push_out(4'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_zero(input string nm);
      checks++;
      if ({gnt, gnt_kritis, bcast_zone, bcast_done, preempted} !== '0) begin
         failures++;
         $display("FAIL %s: got gnt=%b k=%b zone=%0d done=%b pre=%b, want all zero",
                  nm, gnt, gnt_kritis, bcast_zone, bcast_done, preempted);
      end
   endtask

   task automatic step();
      out_t e, a;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = {gnt, gnt_kritis, bcast_zone, bcast_done, preempted};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL %s @%0t: got gnt=%b k=%b zone=%0d done=%b pre=%b, want gnt=%b k=%b zone=%0d done=%b pre=%b",
                     phase, $time, a.g, a.k, a.zone, a.done, a.pre, e.g, e.k, e.zone, e.done, e.pre);
         end
      end
   endtask

   initial begin
      // pointers start at zone 3; each row's winner follows from the rows before it
      vt[0] = '{4'b0000, 4'b0010, 4'b0010, 1'b0};
      vt[1] = '{4'b0000, 4'b0010, 4'b0010, 1'b0};
      vt[2] = '{4'b0000, 4'b1011, 4'b1000, 1'b0};
      vt[3] = '{4'b0000, 4'b1011, 4'b0001, 1'b0};
      vt[4] = '{4'b0100, 4'b0110, 4'b0100, 1'b1};
      vt[5] = '{4'b0101, 4'b0000, 4'b0001, 1'b1};
      vt[6] = '{4'b0000, 4'b1111, 4'b0010, 1'b0};
      vt[7] = '{4'b1000, 4'b0111, 4'b1000, 1'b1};
      vt[8] = '{4'b0000, 4'b0100, 4'b0100, 1'b0};

      reset = 1'b1; kritis_req = '0; invest_req = '0;
      #12;
      check_zero("reset_state");
      @(negedge clk);
      reset = 1'b0;

      // single slots, requests dropped after the first granted clock
      for (int r = 0; r < 9; r++) begin
         phase = $sformatf("vec%0d", r);
         kritis_req = vt[r].k_in;
         invest_req = vt[r].i_in;
         push_slot(vt[r].g, vt[r].gk, BC, 1'b1);
         push_idle(1);
         step();
         kritis_req = '0; invest_req = '0;
         repeat (BC + GC) step();
      end

      // crisis rotation with all zones held
      phase = "kritis_rotate";
      kritis_req = 4'b1111;
      push_slot(4'b0001, 1'b1, BC, 1'b1);
      push_slot(4'b0010, 1'b1, BC, 1'b1);
      push_slot(4'b0100, 1'b1, BC, 1'b1);
      push_slot(4'b1000, 1'b1, BC, 1'b1);
      push_slot(4'b0001, 1'b1, BC, 1'b1);
      push_idle(1);
      for (int c = 0; c < 5 * (BC + GC) + 1; c++) begin
         step();
         if (c == 4 * (BC + GC)) kritis_req = '0;
      end

      // investigation slot aborted by a crisis request on slot clock 3
      phase = "preempt";
      invest_req = 4'b0001;
      push_slot(4'b0001, 1'b0, 3, 1'b0);
      push_slot(4'b0100, 1'b1, BC, 1'b1);
      push_idle(1);
      step();
      invest_req = '0;
      step();
      step();
      kritis_req = 4'b0100;
      step();
      step();
      step();
      kritis_req = '0;
      repeat (BC - 1 + GC + 1) step();

      // reset pulse in the middle of a crisis slot
      phase = "reset_mid";
      kritis_req = 4'b1000;
      for (int c = 0; c < 4; c++) push_out(4'b1000, 1'b1, 1'b0, 1'b0);
      repeat (4) step();
      #2 reset = 1'b1;
      #1 check_zero("reset_async");
      @(negedge clk);
      reset = 1'b0;
      phase = "after_reset";
      push_slot(4'b1000, 1'b1, BC, 1'b1);
      push_idle(1);
      step();
      kritis_req = '0;
      repeat (BC + GC) step();
      phase = "invest_ptr_reset";
      invest_req = 4'b1111;
      push_slot(4'b0001, 1'b0, BC, 1'b1);
      push_idle(1);
      step();
      invest_req = '0;
      repeat (BC + GC) step();

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
